agu_job_arbiter: RTL and testbench
==================================

AGU_JOB_ARBITER -- requirements
Module: agu_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one addr_gen_unit.
REQ-002 Parameter WDOG_CYCLES, default 16'hFFFF: idle cycles in RUN before a job is declared hung.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester job request.
REQ-006 req_ready  output  NUM_REQ  per-requester job accept; the job transfers on valid&ready.
REQ-007 req_desc  input  NUM_REQ x agu_desc_t  per-requester job descriptor: pattern, base_addr, length, stride, width, height, kernel_size.
REQ-008 req_done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-009 req_err  output  1  valid with req_done; 1 = job ended by watchdog.
REQ-010 req_addr  output  ADDR_WIDTH  address broadcast to all requesters.
REQ-011 req_addr_valid  output  NUM_REQ  address valid, asserted only toward the owner.
REQ-012 req_addr_ready  input  NUM_REQ  per-requester address ready.
REQ-013 agu_start  output  1  one-cycle start pulse to addr_gen_unit.
REQ-014 agu_desc  output  agu_desc_t  descriptor driven to addr_gen_unit.
REQ-015 agu_done  input  1  job-complete indication from addr_gen_unit.
REQ-016 agu_addr, agu_addr_valid  input  ADDR_WIDTH, 1  address stream from addr_gen_unit.
REQ-017 agu_addr_ready  output  1  backpressure to addr_gen_unit.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 grant_id  output  $clog2(NUM_REQ)  index of the current owner, valid while busy.

Function
REQ-020 The block SHALL implement the states IDLE, START, RUN, DRAIN and DONE.
REQ-021 IDLE: when any req_valid is set, the block SHALL drive req_ready combinationally high for the round-robin winner only.
- Search starts at rr_ptr and proceeds upward modulo NUM_REQ.
- On the accept cycle the block latches the descriptor and grant_id, then moves to START.
REQ-022 START SHALL last exactly one cycle.
- agu_start=1 in that cycle, which is accept+1.
- Next state is RUN.
- If latched length==0, agu_start stays 0 and the next state is DONE with err=0.
REQ-023 agu_desc SHALL hold the latched descriptor from START until IDLE is re-entered.
REQ-024 In RUN, address routing SHALL be zero-latency and combinational:
- agu_addr_ready = req_addr_ready[owner].
- req_addr_valid[i] = agu_addr_valid when i==owner, else 0.
- req_addr = agu_addr.
REQ-025 In all states except RUN and DRAIN, agu_addr_ready and all req_addr_valid bits SHALL be 0.
REQ-026 RUN SHALL move to DONE with err=0 on the cycle after agu_done is sampled high.
- An address handshake in the same cycle as agu_done SHALL still complete.
REQ-027 Watchdog counter (16 bit):
- Clears on entry to RUN and on every address handshake.
- Increments on every other RUN cycle.
- On reaching WDOG_CYCLES, the block SHALL move to DRAIN.
REQ-028 DRAIN SHALL hold agu_addr_ready=1 and all req_addr_valid=0, discarding addresses, until agu_done is seen; it then moves to DONE with err=1.
REQ-029 DONE SHALL last one cycle.
- req_done[owner]=1 and req_err=err.
- rr_ptr = (owner+1) mod NUM_REQ.
- Next state is IDLE.
- A new accept is possible no earlier than the following cycle.
REQ-030 req_ready SHALL be 0 in every state other than IDLE; requests raised while busy wait.

Reset
REQ-031 While rst is high:
- State = IDLE, rr_ptr = 0, watchdog = 0, latched descriptor = 0, grant_id = 0.
- All outputs SHALL be 0, including req_ready.
REQ-032 Reset asserted mid-job SHALL abandon the job with no req_done pulse; the first post-reset grant SHALL start search at requester 0.

Structure
REQ-033 accel_pkg SHALL hold agu_desc_t (packed, using ADDR_WIDTH and access_pattern_e), agu_arb_state_e and AGU_WDOG_CYCLES_DEFAULT.
REQ-034 Round-robin selection SHALL be a separate combinational sub-module rr_arbiter with inputs req and ptr and outputs gnt_valid and gnt_idx.
- The FSM, watchdog and routing stay in agu_job_arbiter.

Verification
REQ-035 Single job: requester 2 submits SEQUENTIAL, base 0x1000, length 10, owner always ready.
- agu_start one cycle after accept.
- Owner receives 0x1000..0x1009.
- req_done[2]=1 with req_err=0.
REQ-036 Contention: all four requesters valid at once, each with length 4.
- Grants in order 0,1,2,3.
- Requester 0 re-requests after done and is granted only after 3.
REQ-037 Backpressure: owner toggles req_addr_ready every cycle, length 5.
- Exactly 5 addresses delivered in order.
- agu_addr_ready mirrors the owner's ready.
- Non-owners see valid=0.
REQ-038 Zero length: a length-0 job gives no agu_start and req_done with err=0 at accept+2.
REQ-039 Watchdog: WDOG_CYCLES=32, owner holds ready low.
- DRAIN entered after 32 stalled cycles.
- Remaining addresses consumed.
- req_done with req_err=1 after agu_done.
REQ-040 Reset mid-RUN: rst asserted for 1 cycle during a job.
- All outputs 0 and no req_done.
- The next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types for the accelerator address-generation path: job descriptor,
// access pattern encoding and the job-arbiter state set.
package accel_pkg;

  localparam int          ADDR_WIDTH              = 32;
  localparam logic [15:0] AGU_WDOG_CYCLES_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEQUENTIAL  = 2'd0,
    STRIDED     = 2'd1,
    BLOCK_2D    = 2'd2,
    CONV_WINDOW = 2'd3
  } access_pattern_e;

  typedef struct packed {
    access_pattern_e         pattern;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [15:0]             length;
    logic [15:0]             stride;
    logic [15:0]             width;
    logic [15:0]             height;
    logic [3:0]              kernel_size;
  } agu_desc_t;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_START = 3'd1,
    ARB_RUN   = 3'd2,
    ARB_DRAIN = 3'd3,
    ARB_DONE  = 3'd4
  } agu_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_idx
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin : scan
      logic [IDW-1:0] idx;
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/agu_job_arbiter.sv
// Shares one addr_gen_unit among NUM_REQ requesters: round-robin job accept,
// start pulse, owner-only address routing, hang watchdog with drain, done pulse.
module agu_job_arbiter
  import accel_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [15:0] WDOG_CYCLES = AGU_WDOG_CYCLES_DEFAULT,
  localparam int         IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic      [NUM_REQ-1:0]         req_valid,
  output logic      [NUM_REQ-1:0]         req_ready,
  input  agu_desc_t [NUM_REQ-1:0]         req_desc,
  output logic      [NUM_REQ-1:0]         req_done,
  output logic                            req_err,
  output logic      [ADDR_WIDTH-1:0]      req_addr,
  output logic      [NUM_REQ-1:0]         req_addr_valid,
  input  logic      [NUM_REQ-1:0]         req_addr_ready,
  output logic                            agu_start,
  output agu_desc_t                       agu_desc,
  input  logic                            agu_done,
  input  logic      [ADDR_WIDTH-1:0]      agu_addr,
  input  logic                            agu_addr_valid,
  output logic                            agu_addr_ready,
  output logic                            busy,
  output logic      [IDW-1:0]             grant_id
);

  agu_arb_state_e  state_q, state_d;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  rr_ptr_q;
  agu_desc_t       desc_q;
  logic [15:0]     wdog_q;
  logic            err_q;

  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;
  logic            addr_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Only meaningful in RUN, where the owner's ready is forwarded to the AGU.
  assign addr_hs = agu_addr_valid && req_addr_ready[grant_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (gnt_valid) state_d = ARB_START;
      ARB_START: state_d = (desc_q.length == 16'd0) ? ARB_DONE : ARB_RUN;
      ARB_RUN: begin
        if (agu_done)
          state_d = ARB_DONE;
        else if (!addr_hs && (wdog_q + 16'd1 == WDOG_CYCLES))
          state_d = ARB_DRAIN;
      end
      ARB_DRAIN: if (agu_done) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      desc_q   <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ARB_IDLE: begin
          if (gnt_valid) begin
            grant_q <= gnt_idx;
            desc_q  <= req_desc[gnt_idx];
          end
        end
        ARB_START: begin
          wdog_q <= '0;
          err_q  <= 1'b0;
        end
        ARB_RUN: begin
          if (addr_hs) wdog_q <= '0;
          else         wdog_q <= wdog_q + 16'd1;
        end
        ARB_DRAIN: err_q <= 1'b1;
        ARB_DONE: begin
          rr_ptr_q <= (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state and forced low while reset is held.
  always_comb begin
    req_ready      = '0;
    req_done       = '0;
    req_err        = 1'b0;
    req_addr       = '0;
    req_addr_valid = '0;
    agu_start      = 1'b0;
    agu_desc       = '0;
    agu_addr_ready = 1'b0;
    busy           = 1'b0;
    grant_id       = '0;
    if (!rst) begin
      busy     = (state_q != ARB_IDLE);
      grant_id = grant_q;
      agu_desc = desc_q;
      unique case (state_q)
        ARB_IDLE:  if (gnt_valid) req_ready[gnt_idx] = 1'b1;
        ARB_START: agu_start = (desc_q.length != 16'd0);
        ARB_RUN: begin
          agu_addr_ready          = req_addr_ready[grant_q];
          req_addr_valid[grant_q] = agu_addr_valid;
          req_addr                = agu_addr;
        end
        ARB_DRAIN: agu_addr_ready = 1'b1;
        ARB_DONE: begin
          req_done[grant_q] = 1'b1;
          req_err           = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_agu_job_arbiter.sv
// Self-checking bench for agu_job_arbiter: a job-level reference model plus a
// small stand-in AGU, directed scenarios with literal expectations, then random traffic.
module tb_agu_job_arbiter;
  import accel_pkg::*;

  localparam int N    = 4;
  localparam int WDOG = 32;

  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  agu_desc_t [N-1:0]     req_desc;
  logic [N-1:0]          req_done;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [N-1:0]          req_addr_valid;
  logic [N-1:0]          req_addr_ready;
  logic                  agu_start;
  agu_desc_t             agu_desc;
  logic                  agu_done;
  logic [ADDR_WIDTH-1:0] agu_addr;
  logic                  agu_addr_valid;
  logic                  agu_addr_ready;
  logic                  busy;
  logic [1:0]            grant_id;

  always #5 clk = ~clk;

  agu_job_arbiter #(
    .NUM_REQ     (N),
    .WDOG_CYCLES (16'(WDOG))
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_desc       (req_desc),
    .req_done       (req_done),
    .req_err        (req_err),
    .req_addr       (req_addr),
    .req_addr_valid (req_addr_valid),
    .req_addr_ready (req_addr_ready),
    .agu_start      (agu_start),
    .agu_desc       (agu_desc),
    .agu_done       (agu_done),
    .agu_addr       (agu_addr),
    .agu_addr_valid (agu_addr_valid),
    .agu_addr_ready (agu_addr_ready),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // stimulus state
  logic        rst_req;
  int          rdy_mode;
  logic        tgl;
  agu_desc_t   pend_q [N][$];

  // reference model of the arbiter, in job terms
  int          m_phase, m_owner, m_ptr, m_stall;
  logic        m_err;
  agu_desc_t   m_desc;

  // stand-in address generator
  logic        a_active, a_same, a_done_next;
  logic [31:0] a_base;
  int          a_len, a_idx;

  // observations of the DUT
  logic [31:0] rx_q [N][$];
  logic [31:0] last_rx[$];
  int          grant_log[$];
  int          done_owner_q[$];
  int          done_err_q[$];
  int          done_cyc_q[$];
  int          acc_cyc, start_cyc, drain_cyc, n_starts;
  int          abandoned;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic agu_desc_t mk_desc(input logic [31:0] base, input int len);
    agu_desc_t d;
    d             = '0;
    d.pattern     = SEQUENTIAL;
    d.base_addr   = base;
    d.length      = 16'(len);
    d.stride      = 16'd1;
    d.width       = 16'(len);
    d.height      = 16'd1;
    d.kernel_size = 4'd1;
    return d;
  endfunction

  // One clock: drive inputs, predict outputs, compare, then advance model and AGU.
  task automatic step();
    logic [N-1:0] e_ready, e_avalid, e_done;
    logic         e_err, e_start, e_aready, e_busy, hs;
    int           w;
    @(negedge clk);
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pend_q[i].size() != 0);
      req_desc[i]  = req_valid[i] ? pend_q[i][0] : '0;
    end
    case (rdy_mode)
      0: req_addr_ready = '1;
      1: begin tgl = ~tgl; req_addr_ready = {N{tgl}}; end
      2: req_addr_ready = N'($urandom);
      default: req_addr_ready = '0;
    endcase
    agu_addr_valid = a_active && (a_idx < a_len) && ($urandom_range(0, 4) != 0);
    agu_addr       = a_base + 32'(a_idx);

    e_ready = '0; e_avalid = '0; e_done = '0;
    e_err = 1'b0; e_start = 1'b0; e_aready = 1'b0;
    w = -1;
    if (!rst) begin
      case (m_phase)
        M_IDLE: begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (w < 0 && pend_q[c].size() != 0) w = c;
          end
          if (w >= 0) e_ready[w] = 1'b1;
        end
        M_START: e_start = (m_desc.length != 0);
        M_RUN: begin
          e_aready          = req_addr_ready[m_owner];
          e_avalid[m_owner] = agu_addr_valid;
        end
        M_DRAIN: e_aready = 1'b1;
        default: begin
          e_done[m_owner] = 1'b1;
          e_err           = m_err;
        end
      endcase
    end
    e_busy = !rst && (m_phase != M_IDLE);
    hs = agu_addr_valid && e_aready;
    agu_done = !rst && (a_done_next || (a_same && hs && (a_idx == a_len - 1)));
    #1;

    check("req_ready", req_ready, e_ready);
    check("busy", busy, e_busy);
    check("agu_start", agu_start, e_start);
    check("agu_addr_ready", agu_addr_ready, e_aready);
    check("req_addr_valid", req_addr_valid, e_avalid);
    check("req_done", req_done, e_done);
    if (rst || e_done != '0) check("req_err", req_err, e_err);
    if (rst) check("req_addr", req_addr, 0);
    else if (m_phase == M_RUN) check("req_addr", req_addr, agu_addr);
    if (rst) begin
      check("grant_id", grant_id, 0);
      check("agu_desc", agu_desc, 0);
    end else if (m_phase != M_IDLE) begin
      check("grant_id", grant_id, m_owner);
      check("agu_desc", agu_desc, m_desc);
    end

    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin grant_log.push_back(i); acc_cyc = cyc; end
      if (req_done[i]) begin
        done_owner_q.push_back(i);
        done_err_q.push_back(int'(req_err));
        done_cyc_q.push_back(cyc);
      end
      if (req_addr_valid[i] && req_addr_ready[i]) rx_q[i].push_back(req_addr);
    end
    if (agu_start) begin n_starts++; start_cyc = cyc; end
    if (busy && agu_addr_ready && req_addr_ready == '0 && drain_cyc < 0) drain_cyc = cyc;

    if (rst) begin
      m_phase = M_IDLE; m_ptr = 0; m_owner = 0; m_desc = '0; m_stall = 0; m_err = 1'b0;
      a_active = 1'b0; a_done_next = 1'b0; a_idx = 0; a_len = 0;
      for (int i = 0; i < N; i++) rx_q[i].delete();
    end else begin
      if (hs) a_idx++;
      case (m_phase)
        M_IDLE: begin
          if (w >= 0) begin
            m_owner = w;
            m_desc  = pend_q[w].pop_front();
            m_phase = M_START;
          end
        end
        M_START: begin
          if (m_desc.length == 0) begin
            m_phase = M_DONE; m_err = 1'b0;
          end else begin
            m_phase = M_RUN; m_stall = 0;
            a_active = 1'b1; a_base = m_desc.base_addr; a_len = int'(m_desc.length);
            a_idx = 0; a_same = 1'($urandom_range(0, 1)); a_done_next = 1'b0;
          end
        end
        M_RUN: begin
          if (agu_done) begin
            m_phase = M_DONE; m_err = 1'b0;
          end else begin
            m_stall = hs ? 0 : m_stall + 1;
            if (m_stall >= WDOG) m_phase = M_DRAIN;
          end
        end
        M_DRAIN: if (agu_done) begin m_phase = M_DONE; m_err = 1'b1; end
        default: begin
          int mism;
          mism = 0;
          if (!m_err) begin
            check("rx_count", rx_q[m_owner].size(), m_desc.length);
            foreach (rx_q[m_owner][k])
              if (rx_q[m_owner][k] !== m_desc.base_addr + 32'(k)) mism++;
            check("rx_order", mism, 0);
          end
          last_rx = rx_q[m_owner];
          rx_q[m_owner].delete();
          m_ptr   = (m_owner + 1) % N;
          m_phase = M_IDLE;
        end
      endcase
      if (agu_done) begin
        a_active = 1'b0; a_done_next = 1'b0;
      end else if (a_active && a_idx == a_len) begin
        a_done_next = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    run(n);
    rst_req = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (done_owner_q.size() < n && b > 0) begin step(); b--; end
    check(name, done_owner_q.size(), n);
  endtask

  task automatic wait_quiet(input int budget);
    int b, pend;
    b = budget;
    forever begin
      pend = 0;
      for (int i = 0; i < N; i++) pend += pend_q[i].size();
      if ((pend == 0 && m_phase == M_IDLE && !a_active) || b == 0) break;
      step();
      b--;
    end
    check("quiet_timeout", b > 0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int d0, g0, s0;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; rst_req = 1'b1; rdy_mode = 0; tgl = 1'b0;
    req_valid = '0; req_desc = '0; req_addr_ready = '0;
    agu_done = 1'b0; agu_addr = '0; agu_addr_valid = 1'b0;
    m_phase = M_IDLE; m_ptr = 0; m_owner = 0; m_desc = '0; m_stall = 0; m_err = 1'b0;
    a_active = 1'b0; a_same = 1'b0; a_done_next = 1'b0; a_base = '0; a_len = 0; a_idx = 0;
    acc_cyc = 0; start_cyc = 0; drain_cyc = -1; n_starts = 0; abandoned = 0;

    do_reset(3);
    check("rst_busy", busy, 1'b0);

    // Single job from requester 2.
    rdy_mode = 0;
    pend_q[2].push_back(mk_desc(32'h1000, 10));
    d0 = done_owner_q.size();
    wait_dones(d0 + 1, 200, "t1_timeout");
    check("t1_grant", grant_log[$], 2);
    check("t1_start_lat", start_cyc - acc_cyc, 1);
    check("t1_done_owner", done_owner_q[$], 2);
    check("t1_done_err", done_err_q[$], 0);
    check("t1_rx_n", last_rx.size(), 10);
    if (last_rx.size() == 10) begin
      check("t1_rx_first", last_rx[0], 32'h1000);
      check("t1_rx_last", last_rx[9], 32'h1009);
    end

    // Contention: all four at once, requester 0 comes back after its done.
    do_reset(2);
    g0 = grant_log.size();
    d0 = done_owner_q.size();
    for (int i = 0; i < N; i++) pend_q[i].push_back(mk_desc(32'h4000 + 32'(i) * 32'h100, 4));
    wait_dones(d0 + 1, 200, "t2_first_done");
    pend_q[0].push_back(mk_desc(32'h4800, 4));
    wait_dones(d0 + 5, 600, "t2_timeout");
    check("t2_ngrants", grant_log.size() - g0, 5);
    if (grant_log.size() - g0 == 5)
      for (int k = 0; k < 5; k++) check($sformatf("t2_grant%0d", k), grant_log[g0 + k], exp_g[k]);

    // Backpressure: owner ready toggles every cycle.
    rdy_mode = 1;
    d0 = done_owner_q.size();
    pend_q[1].push_back(mk_desc(32'h2000, 5));
    wait_dones(d0 + 1, 200, "t3_timeout");
    check("t3_rx_n", last_rx.size(), 5);
    if (last_rx.size() == 5) begin
      check("t3_rx_first", last_rx[0], 32'h2000);
      check("t3_rx_last", last_rx[4], 32'h2004);
    end
    check("t3_done_err", done_err_q[$], 0);

    // Zero-length job.
    rdy_mode = 0;
    d0 = done_owner_q.size();
    s0 = n_starts;
    pend_q[3].push_back(mk_desc(32'h5000, 0));
    wait_dones(d0 + 1, 50, "t4_timeout");
    check("t4_done_lat", done_cyc_q[$] - acc_cyc, 2);
    check("t4_no_start", n_starts - s0, 0);
    check("t4_done_owner", done_owner_q[$], 3);
    check("t4_done_err", done_err_q[$], 0);

    // Watchdog: owner never ready, job must drain and end with err.
    rdy_mode = 3;
    drain_cyc = -1;
    d0 = done_owner_q.size();
    pend_q[0].push_back(mk_desc(32'h3000, 6));
    wait_dones(d0 + 1, 300, "t5_timeout");
    check("t5_drain_lat", drain_cyc - acc_cyc, 34);
    check("t5_done_err", done_err_q[$], 1);
    check("t5_rx_none", last_rx.size(), 0);

    // Reset in the middle of a running job.
    rdy_mode = 2;
    d0 = done_owner_q.size();
    pend_q[2].push_back(mk_desc(32'h6000, 20));
    run(5);
    check("t6_busy", busy, 1'b1);
    pend_q[3].push_back(mk_desc(32'h7000, 3));
    pend_q[1].push_back(mk_desc(32'h7100, 3));
    g0 = grant_log.size();
    abandoned++;
    do_reset(1);
    begin
      int b;
      b = 50;
      while (grant_log.size() == g0 && b > 0) begin step(); b--; end
    end
    check("t6_regrant", grant_log.size() - g0, 1);
    if (grant_log.size() > g0) check("t6_next_grant", grant_log[g0], 1);
    check("t6_no_done", done_owner_q.size(), d0);
    wait_dones(d0 + 2, 400, "t6_timeout");

    // Random traffic across all requesters and ready behaviours.
    for (int j = 0; j < 6; j++) begin
      rdy_mode = j % 3;
      for (int k = 0; k < 5; k++)
        pend_q[$urandom_range(0, N - 1)].push_back(
          mk_desc($urandom & 32'hFFFF_FF00, int'($urandom_range(0, 12))));
      run(int'($urandom_range(5, 40)));
    end
    wait_quiet(6000);
    check("jobs_balance", done_owner_q.size(), grant_log.size() - abandoned);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
